// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch stage: issues sequential word fetches to the memory
// arbiter, buffers returned words in a small queue and hands one {opcode, pc}
// micro-op per cycle to decode. A taken branch flushes the queue, discards
// any in-flight response and restarts fetch at the redirect target.

// Overflow checker: a push into a full queue without a simultaneous pop
// must never happen because request issue is gated by queue credit.
module fetch_prefetch_queue_chk #(
    parameter int CNT_W       = 3,
    parameter int QUEUE_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] count
);
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count == CNT_W'(QUEUE_DEPTH))));
endmodule

module fetch_prefetch_queue #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          INST_WIDTH  = 32,
    parameter int          QUEUE_DEPTH = 4,
    parameter int unsigned RESET_PC    = 32'd0,
    parameter int unsigned MEM_BYTES   = 32'd64
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  req_valid,
    output logic [ADDR_WIDTH-1:0] Addr,
    input  logic                  grant,
    input  logic [INST_WIDTH-1:0] rdata,
    input  logic                  data_valid,
    input  logic                  Mem_stall,
    input  logic                  system_stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  system_flush,
    output logic                  uop_valid_out,
    output logic [INST_WIDTH-1:0] opcode,
    output logic [ADDR_WIDTH-1:0] pc_out
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_A  = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES_A = ADDR_WIDTH'(MEM_BYTES);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP   = ADDR_WIDTH'(32'd4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Next sequential fetch address; wraps at the end of instruction space
    // unless MEM_BYTES is zero, in which case it wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] seq_pc(input logic [ADDR_WIDTH-1:0] pc);
        logic [ADDR_WIDTH-1:0] inc;
        inc = pc + WORD_STEP;
        if ((MEM_BYTES != 32'd0) && (inc == MEM_BYTES_A)) begin
            return {ADDR_WIDTH{1'b0}};
        end else begin
            return inc;
        end
    endfunction

    state_t                state_r, state_nxt_s;
    logic                  req_valid_r, req_valid_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
    logic [ADDR_WIDTH-1:0] fetch_pc_r, fetch_pc_nxt_s;
    logic [ADDR_WIDTH-1:0] req_pc_r, req_pc_nxt_s;
    logic                  drop_r, drop_nxt_s;
    logic                  push_s, pop_s, credit_s;
    logic [CNT_W-1:0]      count_r, occupancy_s;
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [INST_WIDTH-1:0] q_inst_r [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc_r   [QUEUE_DEPTH];
    logic                  uop_valid_r;
    logic [INST_WIDTH-1:0] opcode_r;
    logic [ADDR_WIDTH-1:0] pc_out_r;

    // The outstanding request reserves a slot so its response always fits.
    assign occupancy_s = count_r + CNT_W'(state_r == ST_WAIT);
    assign credit_s    = (occupancy_s < CNT_W'(QUEUE_DEPTH));
    assign pop_s       = !system_stall && !branch_taken && (count_r != {CNT_W{1'b0}});

    assign req_valid     = req_valid_r;
    assign Addr          = addr_r;
    assign system_flush  = branch_taken;
    assign uop_valid_out = uop_valid_r;
    assign opcode        = opcode_r;
    assign pc_out        = pc_out_r;

    // Fetch FSM next-state and Moore request outputs; branch has top priority.
    always_comb begin
        state_nxt_s     = state_r;
        req_valid_nxt_s = req_valid_r;
        addr_nxt_s      = addr_r;
        req_pc_nxt_s    = req_pc_r;
        drop_nxt_s      = drop_r;
        push_s          = 1'b0;
        if (branch_taken) begin
            fetch_pc_nxt_s = next_pc;
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (branch_taken) begin
                    state_nxt_s = ST_IDLE;
                end else if (credit_s && !Mem_stall) begin
                    state_nxt_s     = ST_REQ;
                    req_valid_nxt_s = 1'b1;
                    addr_nxt_s      = fetch_pc_r;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (grant) begin
                    state_nxt_s     = ST_WAIT;
                    req_valid_nxt_s = 1'b0;
                    req_pc_nxt_s    = addr_r;
                    if (branch_taken) begin
                        drop_nxt_s = 1'b1;
                    end else begin
                        fetch_pc_nxt_s = seq_pc(fetch_pc_r);
                    end
                end else if (branch_taken || Mem_stall) begin
                    state_nxt_s     = ST_IDLE;
                    req_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (data_valid) begin
                    state_nxt_s = ST_IDLE;
                    drop_nxt_s  = 1'b0;
                    push_s      = !drop_r && !branch_taken;
                end else if (branch_taken) begin
                    drop_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                req_valid_nxt_s = 1'b0;
                drop_nxt_s      = 1'b0;
            end
        endcase
    end

    // Fetch FSM state and request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            req_valid_r <= 1'b0;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            fetch_pc_r  <= RESET_PC_A;
            req_pc_r    <= {ADDR_WIDTH{1'b0}};
            drop_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_valid_r <= req_valid_nxt_s;
            addr_r      <= addr_nxt_s;
            fetch_pc_r  <= fetch_pc_nxt_s;
            req_pc_r    <= req_pc_nxt_s;
            drop_r      <= drop_nxt_s;
        end
    end

    // Queue pointers and occupancy; a branch empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (branch_taken) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage write of the returned word and its fetch PC.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_inst_r[wr_ptr_r] <= rdata;
            q_pc_r[wr_ptr_r]   <= req_pc_r;
        end
    end

    // Decode-facing output register: pop head, bubble when empty, hold on stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uop_valid_r <= 1'b0;
            opcode_r    <= {INST_WIDTH{1'b0}};
            pc_out_r    <= {ADDR_WIDTH{1'b0}};
        end else if (branch_taken) begin
            uop_valid_r <= 1'b0;
        end else if (pop_s) begin
            uop_valid_r <= 1'b1;
            opcode_r    <= q_inst_r[rd_ptr_r];
            pc_out_r    <= q_pc_r[rd_ptr_r];
        end else if (!system_stall) begin
            uop_valid_r <= 1'b0;
        end else begin
            uop_valid_r <= uop_valid_r;
        end
    end

    fetch_prefetch_queue_chk #(
        .CNT_W       (CNT_W),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: the bench plays the memory/arbiter with
// randomised grants, latencies, stalls and branches. Every surviving response
// is pushed to an expected-uop queue; a monitor pops and compares each uop.
module tb_fetch_prefetch_queue;
    localparam int DEPTH = 4;
    localparam int MEMB  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] Addr;
    logic        grant;
    logic [31:0] rdata;
    logic        data_valid;
    logic        Mem_stall;
    logic        system_stall;
    logic        branch_taken;
    logic [31:0] next_pc;
    logic        system_flush;
    logic        uop_valid_out;
    logic [31:0] opcode;
    logic [31:0] pc_out;

    fetch_prefetch_queue #(
        .ADDR_WIDTH (32), .INST_WIDTH (32), .QUEUE_DEPTH (DEPTH),
        .RESET_PC (32'd0), .MEM_BYTES (MEMB)
    ) dut (
        .clk (clk), .reset (reset), .req_valid (req_valid), .Addr (Addr),
        .grant (grant), .rdata (rdata), .data_valid (data_valid),
        .Mem_stall (Mem_stall), .system_stall (system_stall),
        .branch_taken (branch_taken), .next_pc (next_pc),
        .system_flush (system_flush), .uop_valid_out (uop_valid_out),
        .opcode (opcode), .pc_out (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] op;
        logic [31:0] pc;
    } uop_t;

    uop_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // memory / program-flow model
    logic [31:0] mpc;
    bit          pending, pend_drop;
    logic [31:0] pend_addr, pend_word;
    int          pend_delay;
    int          grants;
    int          gen = 0;

    // stimulus knobs (percentages and latency range)
    int p_grant, p_stall, p_mstall, p_branch, p_stray, d_min, d_max;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] seq(input logic [31:0] pc);
        return (pc + 32'd4) % MEMB;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pending   = 1'b0;
        pend_drop = 1'b0;
        mpc       = 32'd0;
    endtask

    // One clock of stimulus: decide inputs at the falling edge and record
    // what the program-visible effect of this cycle must be.
    task automatic step();
        bit          br, g, dv, st, ms;
        logic [31:0] nxt, rd;
        @(negedge clk);
        br  = ($urandom_range(99) < p_branch);
        st  = ($urandom_range(99) < p_stall);
        ms  = ($urandom_range(99) < p_mstall);
        nxt = 32'($urandom_range(15)) << 2;
        rd  = $urandom;
        dv  = 1'b0;
        if (req_valid) begin
            chk("req_addr", Addr, mpc);
            chk("credit", exp_q.size() < DEPTH, 1'b1);
            chk("one_outstanding", pending, 1'b0);
        end
        g = req_valid && !ms && ($urandom_range(99) < p_grant);
        if (pending) begin
            if (pend_delay == 0) begin
                dv = 1'b1;
                rd = pend_word;
                if (!pend_drop && !br) exp_q.push_back('{op: pend_word, pc: pend_addr});
                pending = 1'b0;
            end else begin
                pend_delay--;
            end
        end else if (!g && ($urandom_range(99) < p_stray)) begin
            dv = 1'b1;
        end
        if (br) begin
            exp_q.delete();
            if (pending) pend_drop = 1'b1;
            mpc = nxt;
        end
        if (g) begin
            gen++;
            grants++;
            pending    = 1'b1;
            pend_addr  = Addr;
            pend_word  = 32'h100 + Addr + (32'(gen) << 16);
            pend_drop  = br;
            pend_delay = $urandom_range(d_max, d_min);
            if (!br) mpc = seq(mpc);
        end
        grant        = g;
        data_valid   = dv;
        rdata        = rd;
        branch_taken = br;
        next_pc      = nxt;
        system_stall = st;
        Mem_stall    = ms;
        #1;
        chk("flush_out", system_flush, br);
    endtask

    // Monitor: every uop popped by the DUT must match the scoreboard head.
    logic        m_rst, m_st, m_br, m_pv;
    logic [31:0] m_pop, m_ppc;
    uop_t        m_got;
    initial begin
        m_pv = 1'b0; m_pop = 32'd0; m_ppc = 32'd0;
        forever begin
            @(posedge clk);
            m_rst = reset; m_st = system_stall; m_br = branch_taken;
            #1;
            if (m_rst || reset) begin
                // outputs are forced by reset; nothing to compare
            end else if (m_br) begin
                chk("flush_uop", uop_valid_out, 1'b0);
            end else if (m_st) begin
                chk("stall_hold", {uop_valid_out, opcode, pc_out}, {m_pv, m_pop, m_ppc});
            end else if (uop_valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_uop", {opcode, pc_out}, 64'd0 - 64'd1);
                end else begin
                    m_got = exp_q.pop_front();
                    chk("uop", {opcode, pc_out}, {m_got.op, m_got.pc});
                end
            end else begin
                chk("bubble_hold", {opcode, pc_out}, {m_pop, m_ppc});
            end
            m_pv = uop_valid_out; m_pop = opcode; m_ppc = pc_out;
        end
    end

    task automatic set_knobs(input int g, input int st, input int ms, input int br,
                             input int sy, input int dmin, input int dmax);
        p_grant = g; p_stall = st; p_mstall = ms; p_branch = br;
        p_stray = sy; d_min = dmin; d_max = dmax;
    endtask

    initial begin
        int guard;
        reset = 1'b1; grant = 1'b0; rdata = 32'd0; data_valid = 1'b0;
        Mem_stall = 1'b0; system_stall = 1'b0; branch_taken = 1'b0; next_pc = 32'd0;
        model_reset();
        set_knobs(100, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_state", {req_valid, Addr, uop_valid_out, opcode, pc_out}, 128'd0);
        reset = 1'b0;

        // Downstream stall from reset: credit limits prefetch to DEPTH words.
        set_knobs(100, 100, 0, 0, 0, 0, 0);
        grants = 0;
        repeat (20) step();
        chk("stall_grants", grants, DEPTH);
        chk("stall_noreq", req_valid, 1'b0);
        chk("stall_novalid", uop_valid_out, 1'b0);
        p_stall = 0;
        step();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("burst_valid", uop_valid_out, 1'b1);
            chk("burst_pc", pc_out, 32'(i * 4));
        end

        // Sequential fetch through the wrap point of instruction space.
        set_knobs(100, 0, 0, 0, 0, 0, 0);
        repeat (80) step();

        // Random mix of grants, latencies, stalls, branches and stray data.
        set_knobs(60, 20, 15, 4, 10, 0, 3);
        repeat (2500) step();

        // Drain, then build WAIT with two queued words and reset mid-transaction.
        set_knobs(0, 0, 0, 0, 0, 0, 0);
        repeat (15) step();
        set_knobs(100, 100, 0, 0, 0, 0, 0);
        guard = 0;
        while (!(exp_q.size() == 2 && !pending) && guard < 100) begin step(); guard++; end
        d_min = 8; d_max = 8;
        while (!pending && guard < 100) begin step(); guard++; end
        chk("setup_timeout", guard < 100, 1'b1);
        step(); step();
        #2 reset = 1'b1;
        #1 chk("async_reset", {req_valid, Addr, uop_valid_out, opcode, pc_out}, 128'd0);
        grant = 1'b0; data_valid = 1'b0; branch_taken = 1'b0;
        system_stall = 1'b0; Mem_stall = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        // Stale data_valid after reset must never become a uop.
        set_knobs(0, 0, 0, 0, 100, 0, 0);
        repeat (3) step();
        chk("post_reset_req", {req_valid, Addr}, {1'b1, 32'd0});

        set_knobs(60, 20, 15, 4, 10, 0, 3);
        repeat (1500) step();

        // Final drain: every recorded response must have reached decode.
        set_knobs(0, 0, 0, 0, 0, 0, 0);
        repeat (20) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
